// File: rtl/rom_arbiter_pkg.sv
// rtl/rom_arbiter_pkg.sv - shared state/grant encodings and default widths for rom_arbiter
package rom_arbiter_pkg;

  localparam int ADDR_W_DEF = 12;
  localparam int DATA_W_DEF = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    DONE = 2'd2
  } state_e;

  typedef enum logic {
    GNT_A = 1'b0,
    GNT_B = 1'b1
  } gnt_e;

  // The requester that did not win; used to flip priority on a tie
  function automatic logic other_gnt(input logic g);
    return (g == GNT_A) ? GNT_B : GNT_A;
  endfunction

endpackage

// File: rtl/rom_arbiter_rr_picker.sv
// rtl/rom_arbiter_rr_picker.sv - combinational tie-break picker (module rr_picker)
module rr_picker
  import rom_arbiter_pkg::*;
(
  input  logic req_a,
  input  logic req_b,
  input  logic last_gnt,
  output logic grant
);

  // Lone requester wins outright; on a tie the one not granted last wins
  always_comb begin
    grant = GNT_A;
    if (req_a && req_b) begin
      grant = other_gnt(last_gnt);
    end else if (req_b) begin
      grant = GNT_B;
    end
  end

endmodule

// File: rtl/rom_arbiter.sv
// rtl/rom_arbiter.sv - two-requester arbiter for an external combinational ROM; ROUND_ROBIN_EN selects round-robin tie-break
module rom_arbiter
  import rom_arbiter_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_a,
  input  logic              req_b,
  input  logic [ADDR_W-1:0] addr_a,
  input  logic [ADDR_W-1:0] addr_b,
  output logic              ack_a,
  output logic              ack_b,
  output logic [DATA_W-1:0] data_a,
  output logic [DATA_W-1:0] data_b,
  output logic [ADDR_W-1:0] direccion,
  input  logic [DATA_W-1:0] rom_data,
  output logic              busy
);

  state_e              state_q, state_d;
  logic                gnt_q, gnt_d;
  logic [ADDR_W-1:0]   dir_q, dir_d;
  logic [DATA_W-1:0]   data_a_q, data_a_d;
  logic [DATA_W-1:0]   data_b_q, data_b_d;
  logic                ack_a_q, ack_a_d;
  logic                ack_b_q, ack_b_d;
  logic                pick_last;
  logic                winner;

`ifdef ROUND_ROBIN_EN
  logic                last_q, last_d;

  // Reset value B means A holds priority on the first tie
  assign pick_last = last_q;

  // Last-granted pointer, updated at every grant
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_q <= GNT_B;
    end else begin
      last_q <= last_d;
    end
  end
`else
  // Fixed priority: pretending B was granted last makes every tie go to A
  assign pick_last = GNT_B;
`endif

  rr_picker u_picker (
    .req_a    (req_a),
    .req_b    (req_b),
    .last_gnt (pick_last),
    .grant    (winner)
  );

  // State and output registers; reset clears everything, aborting any transaction
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      gnt_q    <= GNT_A;
      dir_q    <= '0;
      data_a_q <= '0;
      data_b_q <= '0;
      ack_a_q  <= 1'b0;
      ack_b_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      dir_q    <= dir_d;
      data_a_q <= data_a_d;
      data_b_q <= data_b_d;
      ack_a_q  <= ack_a_d;
      ack_b_q  <= ack_b_d;
    end
  end

  // Next-state: grant and latch address, capture ROM data, then raise one ack
  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    dir_d    = dir_q;
    data_a_d = data_a_q;
    data_b_d = data_b_q;
    ack_a_d  = 1'b0;
    ack_b_d  = 1'b0;
`ifdef ROUND_ROBIN_EN
    last_d   = last_q;
`endif
    case (state_q)
      IDLE: begin
        if (req_a || req_b) begin
          gnt_d   = winner;
          dir_d   = (winner == GNT_A) ? addr_a : addr_b;
          state_d = READ;
`ifdef ROUND_ROBIN_EN
          last_d  = winner;
`endif
        end
      end
      READ: begin
        if (gnt_q == GNT_A) begin
          data_a_d = rom_data;
        end else begin
          data_b_d = rom_data;
        end
        state_d = DONE;
      end
      DONE: begin
        ack_a_d = (gnt_q == GNT_A);
        ack_b_d = (gnt_q == GNT_B);
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign ack_a     = ack_a_q;
  assign ack_b     = ack_b_q;
  assign data_a    = data_a_q;
  assign data_b    = data_b_q;
  assign direccion = dir_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: doc/rom_arbiter.md
ROM_ARBITER -- requirements
Module: rom_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 12, giving the ROM address width (4096 locations).
REQ-002 The block SHALL have parameter DATA_W, default 8, giving the ROM data width.
REQ-003 The block SHALL have port clk, input, 1, the single rising-edge clock.
REQ-004 The block SHALL have port reset, input, 1, an asynchronous active-low reset.
REQ-005 The block SHALL have ports req_a and req_b, input, 1 each, read requests from requesters A and B.
REQ-006 The block SHALL have ports addr_a and addr_b, input, ADDR_W each, the requested addresses.
REQ-007 The block SHALL have ports ack_a and ack_b, output, 1 each, one-cycle completion pulses.
REQ-008 The block SHALL have ports data_a and data_b, output, DATA_W each, the registered read data per requester.
REQ-009 The block SHALL have port direccion, output, ADDR_W, the registered address driven to the combinational ROM.
REQ-010 The block SHALL have port rom_data, input, DATA_W, the ROM data, valid in the same cycle as direccion.
REQ-011 The block SHALL have port busy, output, 1, high in every state except IDLE.

Function
REQ-012 The FSM SHALL have three states: IDLE, READ and DONE.
REQ-013 In IDLE with any request high, the block SHALL latch the winner's address into direccion, record the grant and move to READ.
REQ-014 In IDLE with no request, the block SHALL stay in IDLE and hold direccion.
REQ-015 In READ, the block SHALL capture rom_data into data_a or data_b, per the grant, and move to DONE.
REQ-016 In DONE, the block SHALL pulse the granted ack for exactly one cycle and return to IDLE.
REQ-017 Ack SHALL rise on the third rising edge after the edge that samples req; a new grant is possible at the earliest in the cycle after ack.
REQ-018 The data output of the non-granted requester SHALL hold its previous value.
REQ-019 A requester SHALL drop req in the cycle after ack; if req is still high in IDLE, the block SHALL treat it as a new request.
REQ-020 If req drops while its transaction is in READ or DONE, the transaction SHALL still complete and ack SHALL still pulse.
REQ-021 Changes to addr_x after the grant SHALL NOT affect the transaction in progress.
REQ-022 When both requests are high in IDLE, the block SHALL grant the requester selected by the priority rule in REQ-026/027.
REQ-023 ack_a and ack_b SHALL never be high in the same cycle.

Reset
REQ-024 On reset low, the block SHALL, immediately and asynchronously, set state to IDLE, and direccion, data_a, data_b, ack_a, ack_b and busy to 0, and the priority pointer to A.
REQ-025 When reset is asserted mid-transaction, the block SHALL abort the transaction with no ack, and the requester SHALL re-issue its request after reset.

Configuration
REQ-026 With ROUND_ROBIN_EN defined, on a tie the block SHALL grant the requester that was not granted last, with the pointer updated at each grant.
REQ-027 Without ROUND_ROBIN_EN, on a tie the block SHALL always grant A (fixed priority), and the pointer SHALL be absent.

Structure
REQ-028 A shared package rom_arbiter_pkg SHALL hold the state encoding (IDLE=2'd0, READ=2'd1, DONE=2'd2), the grant encoding (GNT_A=0, GNT_B=1) and defaults for ADDR_W/DATA_W.
REQ-029 The tie-break logic SHALL be one combinational sub-module, rr_picker, with inputs req_a, req_b and last grant, and output the grant.
REQ-030 The ROM SHALL stay outside the block and connect through direccion/rom_data.

Verification
REQ-031 Test: ROM loaded with data = address[7:0], req_a with addr_a=12'h005 -> direccion=12'h005 after 1 edge, ack_a on 3rd edge, data_a=8'h05, busy high for 2 cycles.
REQ-032 Test: req_a and req_b both high from IDLE, addr_a=12'h010, addr_b=12'h020, ROUND_ROBIN_EN defined -> grants in order A, B, A, B, with data_b=8'h20 at each B ack.
REQ-033 Test: the same stimulus without ROUND_ROBIN_EN -> only A is granted while req_a stays high, and ack_b never rises.
REQ-034 Test: req_b with addr_b=12'hFFF, then addr_b changed to 12'h000 in READ -> data_b=8'hFF; data_a unchanged.
REQ-035 Test: reset pulled low during READ -> all outputs 0 immediately, no ack, and a new request after release completes normally.
REQ-036 Test: req_a dropped in READ -> ack_a still pulses once, and the FSM returns to IDLE.
